// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle MIPS-subset control FSM with memory-stall watchdog
// Optional feature macro: MC_CTRL_BNE_EN (decode bne, op 5, into EXEC_B and drive branch_ne).
module multicycle_ctrl #(
    parameter int TO_W        = 8,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       reg_rt,
    output logic       alu_imm,
    output logic       branch,
    output logic       branch_ne,
    output logic       jump,
    output logic [2:0] aluc,
    output logic [3:0] state,
    output logic       instr_done,
    output logic       illegal,
    output logic       mem_err
);

    localparam logic [5:0] OP_R   = 6'd0;
    localparam logic [5:0] OP_J   = 6'd2;
    localparam logic [5:0] OP_BEQ = 6'd4;
    localparam logic [5:0] OP_BNE = 6'd5;
    localparam logic [5:0] OP_LW  = 6'd35;
    localparam logic [5:0] OP_SW  = 6'd43;
    localparam logic [TO_W-1:0] WD_LAST = TO_W'(MEM_TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC_R = 4'd2,
        S_WB_R   = 4'd3,
        S_EXEC_M = 4'd4,
        S_MEM    = 4'd5,
        S_WB_M   = 4'd6,
        S_EXEC_B = 4'd7,
        S_JUMP   = 4'd8
    } state_t;

    state_t          st;
    state_t          dec_next;
    logic [5:0]      op_q;
    logic [5:0]      func_q;
    logic [TO_W-1:0] wd;
    logic [TO_W-1:0] wd_inc;
    logic            wd_expired;
    logic            r_legal;
    logic [2:0]      r_aluc;

    assign state      = st;
    assign wd_expired = (MEM_TIMEOUT != 0) && (wd == WD_LAST);
    assign wd_inc     = (wd == '1) ? wd : wd + TO_W'(1);

    always_comb begin
        r_aluc  = 3'b010;
        r_legal = 1'b1;
        case (func_q)
            6'd32:   r_aluc = 3'b010;
            6'd34:   r_aluc = 3'b110;
            6'd36:   r_aluc = 3'b000;
            6'd37:   r_aluc = 3'b001;
            6'd39:   r_aluc = 3'b100;
            6'd42:   r_aluc = 3'b111;
            default: r_legal = 1'b0;
        endcase

        dec_next = S_FETCH;
        if (op_q == OP_R && r_legal)
            dec_next = S_EXEC_R;
        else if (op_q == OP_LW || op_q == OP_SW)
            dec_next = S_EXEC_M;
        else if (op_q == OP_BEQ)
            dec_next = S_EXEC_B;
`ifdef MC_CTRL_BNE_EN
        else if (op_q == OP_BNE)
            dec_next = S_EXEC_B;
`endif
        else if (op_q == OP_J)
            dec_next = S_JUMP;
    end

    // Watchdog defaults to clear; only a stalled FETCH/MEM cycle keeps counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            st         <= S_FETCH;
            op_q       <= '0;
            func_q     <= '0;
            wd         <= '0;
            instr_done <= 1'b0;
            illegal    <= 1'b0;
            mem_err    <= 1'b0;
        end else begin
            wd         <= '0;
            instr_done <= 1'b0;
            illegal    <= 1'b0;
            mem_err    <= 1'b0;
            case (st)
                S_FETCH: begin
                    if (mem_ready) begin
                        st     <= S_DECODE;
                        op_q   <= op;
                        func_q <= func;
                    end else if (wd_expired) begin
                        mem_err <= 1'b1;
                    end else begin
                        wd <= wd_inc;
                    end
                end
                S_DECODE: begin
                    st      <= dec_next;
                    illegal <= (dec_next == S_FETCH);
                end
                S_EXEC_R: st <= S_WB_R;
                S_EXEC_M: st <= S_MEM;
                S_MEM: begin
                    if (mem_ready) begin
                        if (op_q == OP_LW) begin
                            st <= S_WB_M;
                        end else begin
                            st         <= S_FETCH;
                            instr_done <= 1'b1;
                        end
                    end else if (wd_expired) begin
                        st      <= S_FETCH;
                        mem_err <= 1'b1;
                    end else begin
                        wd <= wd_inc;
                    end
                end
                S_WB_R, S_WB_M, S_EXEC_B, S_JUMP: begin
                    st         <= S_FETCH;
                    instr_done <= 1'b1;
                end
                default: st <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg_rt     = 1'b0;
        alu_imm    = 1'b0;
        branch     = 1'b0;
        branch_ne  = 1'b0;
        jump       = 1'b0;
        aluc       = 3'b000;
        case (st)
            S_FETCH: begin
                mem_read = 1'b1;
                aluc     = 3'b010;
                ir_write = mem_ready;
                pc_write = mem_ready;
            end
            S_DECODE: aluc = 3'b010;
            S_EXEC_R: aluc = r_aluc;
            S_WB_R: begin
                reg_write = 1'b1;
                aluc      = r_aluc;
            end
            S_EXEC_M: begin
                alu_imm = 1'b1;
                aluc    = 3'b010;
            end
            S_MEM: begin
                alu_imm   = 1'b1;
                aluc      = 3'b010;
                mem_read  = (op_q == OP_LW);
                mem_write = (op_q == OP_SW);
            end
            S_WB_M: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                reg_rt     = 1'b1;
            end
            S_EXEC_B: begin
                aluc = 3'b110;
`ifdef MC_CTRL_BNE_EN
                branch    = (op_q == OP_BEQ);
                branch_ne = (op_q == OP_BNE);
`else
                branch    = 1'b1;
`endif
            end
            S_JUMP: begin
                jump     = 1'b1;
                pc_write = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - randomized self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;
    localparam int T = 4;

    localparam logic [10:0] F_PCW  = 11'h400;
    localparam logic [10:0] F_IRW  = 11'h200;
    localparam logic [10:0] F_MR   = 11'h100;
    localparam logic [10:0] F_MW   = 11'h080;
    localparam logic [10:0] F_RW   = 11'h040;
    localparam logic [10:0] F_MTR  = 11'h020;
    localparam logic [10:0] F_RRT  = 11'h010;
    localparam logic [10:0] F_AIMM = 11'h008;
    localparam logic [10:0] F_BR   = 11'h004;
    localparam logic [10:0] F_BNE  = 11'h002;
    localparam logic [10:0] F_JMP  = 11'h001;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] op = '0;
    logic [5:0] func = '0;
    logic       mem_ready = 1'b0;
    logic       pc_write, ir_write, mem_read, mem_write;
    logic       reg_write, mem_to_reg, reg_rt, alu_imm;
    logic       branch, branch_ne, jump;
    logic [2:0] aluc;
    logic [3:0] state;
    logic       instr_done, illegal, mem_err;
    logic [13:0] obs;

    int n_checks = 0;
    int n_fail   = 0;
    logic p_done = 1'b0;
    logic p_ill  = 1'b0;
    logic p_err  = 1'b0;

    typedef struct packed {
        logic [3:0]  st;
        logic [10:0] f;
        logic [2:0]  a;
        logic        rdy;
        logic        done;
        logic        ill;
        logic        err;
    } cyc_t;
    cyc_t q[$];

    always #5 clk = ~clk;

    multicycle_ctrl #(.TO_W(8), .MEM_TIMEOUT(T)) dut (
        .clk(clk), .rst(rst), .op(op), .func(func), .mem_ready(mem_ready),
        .pc_write(pc_write), .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .reg_rt(reg_rt), .alu_imm(alu_imm),
        .branch(branch), .branch_ne(branch_ne), .jump(jump), .aluc(aluc), .state(state),
        .instr_done(instr_done), .illegal(illegal), .mem_err(mem_err)
    );

    assign obs = {pc_write, ir_write, mem_read, mem_write, reg_write, mem_to_reg,
                  reg_rt, alu_imm, branch, branch_ne, jump, aluc};

    // Instruction class: 0 illegal, 1 R-type, 2 lw, 3 sw, 4 beq, 5 bne, 6 j
    function automatic int kind(input logic [5:0] o, input logic [5:0] f);
        if (o == 6'd0)
            return (f inside {6'd32, 6'd34, 6'd36, 6'd37, 6'd39, 6'd42}) ? 1 : 0;
        if (o == 6'd35) return 2;
        if (o == 6'd43) return 3;
        if (o == 6'd4)  return 4;
`ifdef MC_CTRL_BNE_EN
        if (o == 6'd5)  return 5;
`endif
        if (o == 6'd2)  return 6;
        return 0;
    endfunction

    function automatic logic [2:0] alu_of(input logic [5:0] f);
        case (f)
            6'd34:   return 3'b110;
            6'd36:   return 3'b000;
            6'd37:   return 3'b001;
            6'd39:   return 3'b100;
            6'd42:   return 3'b111;
            default: return 3'b010;
        endcase
    endfunction

    function automatic void push(input logic [3:0] s, input logic [10:0] f, input logic [2:0] a,
                                 input logic rdy, input logic done, input logic ill, input logic err);
        cyc_t e;
        e.st = s; e.f = f; e.a = a; e.rdy = rdy; e.done = done; e.ill = ill; e.err = err;
        q.push_back(e);
    endfunction

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expected cycle trace of one instruction given fetch and memory wait counts
    function automatic void build(input logic [5:0] o, input logic [5:0] f, input int fw, input int mw);
        int c = 0;
        int k = kind(o, f);
        logic [10:0] mf;
        for (int i = 0; i < fw; i++) begin
            c++;
            push(4'd0, F_MR, 3'b010, 1'b0, 1'b0, 1'b0, c == T);
            if (c == T) c = 0;
        end
        push(4'd0, F_PCW | F_IRW | F_MR, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0);
        push(4'd1, 11'h0, 3'b010, rnd(), 1'b0, k == 0, 1'b0);
        case (k)
            1: begin
                push(4'd2, 11'h0, alu_of(f), rnd(), 1'b0, 1'b0, 1'b0);
                push(4'd3, F_RW, alu_of(f), rnd(), 1'b1, 1'b0, 1'b0);
            end
            2, 3: begin
                mf = (k == 2) ? F_MR : F_MW;
                push(4'd4, F_AIMM, 3'b010, rnd(), 1'b0, 1'b0, 1'b0);
                if (mw >= T) begin
                    for (int i = 0; i < T; i++)
                        push(4'd5, F_AIMM | mf, 3'b010, 1'b0, 1'b0, 1'b0, i == T - 1);
                end else begin
                    for (int i = 0; i < mw; i++)
                        push(4'd5, F_AIMM | mf, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
                    push(4'd5, F_AIMM | mf, 3'b010, 1'b1, k == 3, 1'b0, 1'b0);
                    if (k == 2)
                        push(4'd6, F_RW | F_MTR | F_RRT, 3'b000, rnd(), 1'b1, 1'b0, 1'b0);
                end
            end
            4: push(4'd7, F_BR, 3'b110, rnd(), 1'b1, 1'b0, 1'b0);
            5: push(4'd7, F_BNE, 3'b110, rnd(), 1'b1, 1'b0, 1'b0);
            6: push(4'd8, F_JMP | F_PCW, 3'b000, rnd(), 1'b1, 1'b0, 1'b0);
            default: ;
        endcase
    endfunction

    task automatic run_queue(input string name, input logic [5:0] iop, input logic [5:0] ifunc);
        int cyc = 0;
        while (q.size() > 0) begin
            cyc_t e = q.pop_front();
            @(posedge clk);
            #1;
            mem_ready = e.rdy;
            if (e.st == 4'd0) begin
                op = iop; func = ifunc;
            end else begin
                op = 6'($urandom); func = 6'($urandom);
            end
            @(negedge clk);
            n_checks++;
            if (state !== e.st) begin
                n_fail++;
                $display("FAIL %s state cyc %0d: got %0d expected %0d", name, cyc, state, e.st);
            end
            n_checks++;
            if (obs !== {e.f, e.a}) begin
                n_fail++;
                $display("FAIL %s outputs cyc %0d: got %h expected %h", name, cyc, obs, {e.f, e.a});
            end
            n_checks++;
            if ({instr_done, illegal, mem_err} !== {p_done, p_ill, p_err}) begin
                n_fail++;
                $display("FAIL %s pulses cyc %0d: got %b expected %b", name, cyc,
                         {instr_done, illegal, mem_err}, {p_done, p_ill, p_err});
            end
            p_done = e.done; p_ill = e.ill; p_err = e.err;
            cyc++;
        end
    endtask

    task automatic do_instr(input string name, input logic [5:0] o, input logic [5:0] f,
                            input int fw, input int mw);
        build(o, f, fw, mw);
        run_queue(name, o, f);
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (state !== 4'd0 || obs !== {F_MR, 3'b010} || {instr_done, illegal, mem_err} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_init: state %0d outs %h pulses %b", state, obs, {instr_done, illegal, mem_err});
        end
        op = 6'd43; mem_ready = 1'b1;
        @(posedge clk);
        #1 mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (state !== 4'd5 || mem_write !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_pre_mem: state %0d mem_write %b expected 5/1", state, mem_write);
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (state !== 4'd0 || mem_write !== 1'b0 || mem_read !== 1'b1 || aluc !== 3'b010 ||
            {instr_done, illegal, mem_err} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_mid_mem: state %0d mw %b mr %b aluc %b pulses %b", state, mem_write,
                     mem_read, aluc, {instr_done, illegal, mem_err});
        end
        p_done = 1'b0; p_ill = 1'b0; p_err = 1'b0;
    endtask

    task automatic test_add();
        do_instr("add", 6'd0, 6'd32, 0, 0);
    endtask

    task automatic test_lw_wait();
        do_instr("lw_wait", 6'd35, 6'd0, 0, 2);
    endtask

    task automatic test_timeout();
        do_instr("sw_timeout", 6'd43, 6'd0, 0, T + 3);
        do_instr("fetch_timeout", 6'd0, 6'd37, T + 1, 0);
        do_instr("sw_ok", 6'd43, 6'd9, 0, T - 1);
    endtask

    task automatic test_illegal();
        do_instr("illegal_63", 6'd63, 6'd32, 0, 0);
        do_instr("illegal_sll", 6'd0, 6'd0, 0, 0);
    endtask

    task automatic test_branch();
        do_instr("beq", 6'd4, 6'd0, 0, 0);
        do_instr("bne", 6'd5, 6'd0, 0, 0);
        do_instr("j", 6'd2, 6'd0, 1, 0);
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops[8]   = '{6'd0, 6'd0, 6'd2, 6'd4, 6'd5, 6'd35, 6'd43, 6'd63};
        logic [5:0] funcs[8] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd39, 6'd42, 6'd0, 6'd17};
        for (int i = 0; i < 60; i++) begin
            logic [5:0] o = ops[$urandom_range(0, 7)];
            logic [5:0] f = funcs[$urandom_range(0, 7)];
            int mw = ($urandom_range(0, 5) == 0) ? T + 1 : int'($urandom_range(0, 2));
            if ($urandom_range(0, 9) == 0) o = 6'($urandom);
            do_instr("random", o, f, int'($urandom_range(0, 1)), mw);
        end
        push(4'd0, F_MR, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
        run_queue("tail", 6'd0, 6'd0);
    endtask

    initial begin
        test_reset();
        test_add();
        test_lw_wait();
        test_timeout();
        test_illegal();
        test_branch();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
